// File: rtl/fpu_requester.sv
// Client-side sequencer for the fpu block: queues tagged commands, pulses the
// FPU reset, runs the operand/result handshake and returns result or timeout.
module fpu_requester #(
  parameter int WIDTH     = 32,
  parameter int OP_WIDTH  = 4,
  parameter int TAG_WIDTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_WIDTH-1:0]  cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic [TAG_WIDTH-1:0] cmd_tag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic                 res_timeout,
  output logic                 fpu_reset,
  output logic [OP_WIDTH-1:0]  operation,
  output logic [WIDTH-1:0]     data_a,
  output logic [WIDTH-1:0]     data_b,
  output logic                 input_rdy,
  input  logic                 input_ack,
  input  logic                 output_rdy,
  output logic                 output_ack,
  input  logic [WIDTH-1:0]     result
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [OP_WIDTH-1:0]  op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [TAG_WIDTH-1:0] tag;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQUEST, S_WAIT, S_ACK, S_ABORT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  cmd_t             fifo_q [2];
  cmd_t             cmd_q, cmd_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             to_q, to_d;
  logic             push, pop, tmo;

  // Full is judged on the registered count only; a same-cycle pop does not help.
  assign cmd_ready = ~count_q[1];
  assign push      = cmd_valid & cmd_ready;
  assign count_d   = count_q + 2'(push) - 2'(pop);
  assign cmd_d     = pop ? fifo_q[rd_ptr_q] : cmd_q;
  assign tmo       = (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    cnt_d      = cnt_q;
    res_d      = res_q;
    to_d       = to_q;
    fpu_reset  = 1'b0;
    input_rdy  = 1'b0;
    output_ack = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        fpu_reset = 1'b1;
        cnt_d     = '0;
        state_d   = S_REQUEST;
      end
      S_REQUEST: begin
        input_rdy = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (input_ack && output_rdy) begin
          res_d   = result;
          state_d = S_ACK;
        end else if (input_ack) state_d = S_WAIT;
        else if (tmo)           state_d = S_ABORT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (output_rdy) begin
          res_d   = result;
          state_d = S_ACK;
        end else if (tmo) state_d = S_ABORT;
      end
      S_ACK: begin
        output_ack = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (!output_rdy) begin
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (tmo) state_d = S_ABORT;
      end
      S_ABORT: begin
        // Second reset pulse flushes the stalled FPU; all-ones reads as NaN.
        fpu_reset = 1'b1;
        res_d     = '1;
        to_d      = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign operation   = cmd_q.op;
  assign data_a      = cmd_q.a;
  assign data_b      = cmd_q.b;
  assign res_tag     = cmd_q.tag;
  assign res_data    = res_q;
  assign res_timeout = to_q;

endmodule

// File: tb/tb_fpu_requester.sv
// Directed bench for fpu_requester against a small behavioural FPU handshake model.
module tb_fpu_requester;
  logic        clock, reset, cmd_valid, cmd_ready, res_valid, res_ready, res_timeout;
  logic        fpu_reset, input_rdy, input_ack, output_rdy, output_ack;
  logic [3:0]  cmd_op, cmd_tag, res_tag, operation;
  logic [31:0] cmd_a, cmd_b, res_data, data_a, data_b, result;

  int tests = 0, fails = 0;

  // FPU model knobs: mode 0 = ack then result, 1 = ack and result together, 2 = never result
  int          fm_mode = 0, fm_delay = 0, fm_hold = 0;
  bit          fm_echo = 0;
  logic [31:0] fm_result = '0;
  int          mst, mcnt, hcnt;

  fpu_requester #(.WIDTH(32), .OP_WIDTH(4), .TAG_WIDTH(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .res_timeout(res_timeout), .fpu_reset(fpu_reset), .operation(operation),
    .data_a(data_a), .data_b(data_b), .input_rdy(input_rdy), .input_ack(input_ack),
    .output_rdy(output_rdy), .output_ack(output_ack), .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  initial begin
    input_ack = 1'b0; output_rdy = 1'b0; result = '0; mst = 0; mcnt = 0; hcnt = 0;
    forever begin
      tick();
      if (reset || fpu_reset) begin
        input_ack = 1'b0; output_rdy = 1'b0; mst = 0; mcnt = 0; hcnt = 0;
      end else begin
        case (mst)
          0: if (input_rdy) begin
               mcnt++;
               if (mcnt >= fm_delay) begin
                 input_ack = 1'b1;
                 if (fm_mode == 1) begin
                   output_rdy = 1'b1;
                   result = fm_echo ? (data_a ^ data_b) : fm_result;
                 end
                 mst = 1;
               end
             end
          1: begin
               input_ack = 1'b0;
               if (fm_mode == 0) begin
                 output_rdy = 1'b1;
                 result = fm_echo ? (data_a ^ data_b) : fm_result;
                 mst = 2;
               end else if (fm_mode == 1) mst = 2;
             end
          2: if (output_ack) begin
               hcnt++;
               if (hcnt > fm_hold) begin output_rdy = 1'b0; mst = 3; end
             end
          default: mst = 0;
        endcase
      end
    end
  end

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget, output bit ok);
    int k = 0;
    while (!res_valid && k < budget) begin tick(); k++; end
    ok = res_valid;
  endtask

  task automatic consume();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    tests++; if ({res_valid, fpu_reset, input_rdy, output_ack, res_timeout} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000", {res_valid, fpu_reset, input_rdy, output_ack, res_timeout}); end
    tests++; if ({res_data, res_tag, operation, data_a, data_b} !== '0) begin
      fails++; $display("FAIL reset_data: got %h expected 0", {res_data, res_tag, operation, data_a, data_b}); end
  endtask

  task automatic test_multiply();
    int k = 0, pulses = 0;
    bit ok;
    fm_mode = 0; fm_delay = 2; fm_hold = 0; fm_echo = 0; fm_result = 32'h40800000;
    push(4'b0010, 32'h40000000, 32'h40000000, 4'd3);
    while (!input_rdy && k < 10) begin
      if (fpu_reset) pulses++;
      tick(); k++;
    end
    tests++; if (k !== 2) begin fails++; $display("FAIL mul_input_rdy_latency: got %0d expected 2", k); end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL mul_reset_pulses: got %0d expected 1", pulses); end
    tests++; if ({operation, data_a, data_b} !== {4'b0010, 32'h40000000, 32'h40000000}) begin
      fails++; $display("FAIL mul_operands: got %h expected 24000000040000000", {operation, data_a, data_b}); end
    wait_res(30, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mul_res_valid: got 0 expected 1"); end
    tests++; if ({res_data, res_tag, res_timeout} !== {32'h40800000, 4'd3, 1'b0}) begin
      fails++; $display("FAIL mul_result: got %h/%h/%b expected 40800000/3/0", res_data, res_tag, res_timeout); end
    consume();
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL mul_res_release: got %b expected 0", res_valid); end
  endtask

  task automatic test_add_same_cycle();
    int k = 0, acks = 0, gaps = 0;
    bit seen_req = 0;
    fm_mode = 1; fm_delay = 0; fm_hold = 2; fm_echo = 0; fm_result = 32'h3F8147AE;
    push(4'b0000, 32'h3F800000, 32'h3C23D70A, 4'd5);
    while (!res_valid && k < 30) begin
      if (input_rdy) seen_req = 1;
      if (output_ack) acks++;
      if (seen_req && acks == 0 && !input_rdy) gaps++;
      tick(); k++;
    end
    tests++; if (gaps !== 0) begin fails++; $display("FAIL add_wait_skipped: got %0d idle cycles expected 0", gaps); end
    tests++; if (acks !== 4) begin fails++; $display("FAIL add_output_ack_hold: got %0d cycles expected 4", acks); end
    tests++; if ({res_valid, res_data, res_tag, res_timeout} !== {1'b1, 32'h3F8147AE, 4'd5, 1'b0}) begin
      fails++; $display("FAIL add_result: got %b/%h/%h/%b expected 1/3f8147ae/5/0", res_valid, res_data, res_tag, res_timeout); end
    consume();
  endtask

  task automatic test_queue_full();
    logic [3:0]  tags  [4];
    logic [31:0] datas [4];
    int got = 0, last = 0;
    bit ok, pend = 0;
    fm_mode = 0; fm_delay = 0; fm_hold = 0; fm_echo = 1;
    push(4'b0000, 32'h101, 32'h0, 4'd1);
    wait_res(30, ok);
    tests++; if (!ok) begin fails++; $display("FAIL q_first_res_valid: got 0 expected 1"); end
    push(4'b0000, 32'h102, 32'h0, 4'd2);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL q_ready_after_1: got %b expected 1", cmd_ready); end
    push(4'b0000, 32'h103, 32'h0, 4'd3);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL q_ready_after_2: got %b expected 0", cmd_ready); end
    cmd_op = 4'b0000; cmd_a = 32'h104; cmd_b = 32'h0; cmd_tag = 4'd4; cmd_valid = 1'b1;
    tick(); tick(); tick();
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL q_ready_stall: got %b expected 0", cmd_ready); end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (fpu_reset && pend) begin
        pend = 0;
        tests++; if (k - last !== 2) begin fails++; $display("FAIL q_next_clear_gap: got %0d expected 2", k - last); end
      end
      if (res_valid) begin
        if (got < 4) begin tags[got] = res_tag; datas[got] = res_data; end
        got++; last = k; pend = 1;
      end
      tick();
    end
    res_ready = 1'b0;
    tests++; if (got !== 3) begin fails++; $display("FAIL q_result_count: got %0d expected 3", got); end
    tests++; if ({tags[0], tags[1], tags[2]} !== {4'd1, 4'd2, 4'd3}) begin
      fails++; $display("FAIL q_tag_order: got %h expected 123", {tags[0], tags[1], tags[2]}); end
    tests++; if ({datas[0], datas[1], datas[2]} !== {32'h101, 32'h102, 32'h103}) begin
      fails++; $display("FAIL q_data_order: got %h/%h/%h expected 101/102/103", datas[0], datas[1], datas[2]); end
  endtask

  task automatic test_timeout();
    int k = 0;
    bit ok;
    fm_mode = 2; fm_delay = 0; fm_hold = 0; fm_echo = 0;
    push(4'b0010, 32'h1, 32'h2, 4'd7);
    while (!input_rdy && k < 10) begin tick(); k++; end
    k = 0;
    while (!fpu_reset && k < 20) begin tick(); k++; end
    tests++; if (k !== 8) begin fails++; $display("FAIL to_abort_cycle: got %0d expected 8", k); end
    wait_res(10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL to_res_valid: got 0 expected 1"); end
    tests++; if ({res_data, res_tag, res_timeout} !== {32'hFFFFFFFF, 4'd7, 1'b1}) begin
      fails++; $display("FAIL to_result: got %h/%h/%b expected ffffffff/7/1", res_data, res_tag, res_timeout); end
    consume();
    fm_mode = 0; fm_echo = 1;
    push(4'b0000, 32'h1234, 32'h0, 4'd8);
    wait_res(30, ok);
    tests++; if ({ok, res_data, res_tag, res_timeout} !== {1'b1, 32'h1234, 4'd8, 1'b0}) begin
      fails++; $display("FAIL to_recover: got %b/%h/%h/%b expected 1/1234/8/0", ok, res_data, res_tag, res_timeout); end
    consume();
  endtask

  task automatic test_divide();
    int bad = 0;
    bit ok;
    fm_mode = 0; fm_delay = 1; fm_hold = 0; fm_echo = 0; fm_result = 32'h40000000;
    push(4'b0011, 32'h40800000, 32'h40000000, 4'hC);
    wait_res(30, ok);
    tests++; if (!ok) begin fails++; $display("FAIL div_res_valid: got 0 expected 1"); end
    for (int k = 0; k < 10; k++) begin
      if ({res_valid, res_data, res_tag} !== {1'b1, 32'h40000000, 4'hC}) bad++;
      tick();
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL div_stall_stable: got %0d unstable cycles expected 0", bad); end
    consume();
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL div_release: got %b expected 0", res_valid); end
  endtask

  task automatic test_reset_mid();
    int k = 0, stale = 0;
    fm_mode = 2; fm_delay = 0;
    push(4'b0010, 32'h55, 32'h66, 4'd9);
    while (!input_rdy && k < 10) begin tick(); k++; end
    push(4'b0000, 32'h77, 32'h88, 4'd10);
    reset = 1'b1; tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_cmd_ready: got %b expected 1", cmd_ready); end
    tests++; if ({res_valid, fpu_reset, input_rdy, output_ack, res_timeout} !== 5'b0) begin
      fails++; $display("FAIL mid_ctrl: got %b expected 00000", {res_valid, fpu_reset, input_rdy, output_ack, res_timeout}); end
    tests++; if ({res_data, res_tag, operation, data_a, data_b} !== '0) begin
      fails++; $display("FAIL mid_data: got %h expected 0", {res_data, res_tag, operation, data_a, data_b}); end
    reset = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (res_valid || input_rdy || fpu_reset) stale++;
      tick();
    end
    tests++; if (stale !== 0) begin fails++; $display("FAIL mid_stale_activity: got %0d cycles expected 0", stale); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    test_reset();
    test_multiply();
    test_add_same_cycle();
    test_queue_full();
    test_timeout();
    test_divide();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_requester.md
# fpu_requester

Initiator side of the FPU operand/result handshake. Accepts tagged commands (operation plus two operands) from a client port into a 2-entry queue. For each command it pulses the FPU reset, presents operands with `input_rdy` until `input_ack`, then collects the result with `output_ack`. It returns result, tag and status to the client, and aborts with a timeout status if the FPU stalls. It sits between the issue stage and the `fpu` block, replacing bench-style hand-driven sequencing.

## Interface
- `WIDTH`, 32: operand/result width (IEEE-754 single).
- `OP_WIDTH`, 4: FPU operation code width (0000 add, 0010 mul, 0011 div).
- `TAG_WIDTH`, 4: client tag width, returned unchanged with the result.
- `TIMEOUT`, 64: maximum cycles from leaving CLEAR to completing ACK; must be at least 4.

- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  client command valid.
- `cmd_ready`  out  1  queue not full.
- `cmd_op`  in  OP_WIDTH  operation.
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `cmd_tag`  in  TAG_WIDTH  tag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  client accepts result.
- `res_data`  out  WIDTH  result.
- `res_tag`  out  TAG_WIDTH  tag of the completed command.
- `res_timeout`  out  1  1 = aborted by timeout.
- `fpu_reset`  out  1  drives `fpu.reset`.
- `operation`  out  OP_WIDTH  drives `fpu.operation`.
- `data_a`, `data_b`  out  WIDTH  drive `fpu.data_a` and `fpu.data_b`.
- `input_rdy`  out  1  operands valid.
- `input_ack`  in  1  FPU accepted operands.
- `output_rdy`  in  1  FPU result valid.
- `output_ack`  out  1  result consumed.
- `result`  in  WIDTH  FPU result.

## Operation
- **Queue:** 2-entry FIFO of {op, a, b, tag}.
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. It is not relaxed by a same-cycle pop.
  - Pop only in IDLE when non-empty.
- **Command register:** the popped entry is latched into the command register. `operation`, `data_a` and `data_b` come from this register and stay stable until the next pop.
- **State machine:**
  - IDLE: all handshake outputs 0. If the FIFO is non-empty, pop and go to CLEAR.
  - CLEAR: `fpu_reset` = 1 for exactly one cycle. Clear the timeout counter. Go to REQUEST.
  - REQUEST: `input_rdy` = 1.
    - If `input_ack && output_rdy`: capture `result`, go to ACK.
    - Else if `input_ack`: go to WAIT.
  - WAIT: `input_rdy` = 0. On `output_rdy`: capture `result`, go to ACK.
  - ACK: `output_ack` = 1. When `output_rdy` is sampled 0, go to DONE with `res_timeout` = 0.
  - ABORT: `fpu_reset` = 1 for one cycle. Result register = all ones (NaN), `res_timeout` = 1. Go to DONE.
  - DONE: `res_valid` = 1 and result outputs held. On `res_ready`, go to IDLE.
- **Timeout counter:** increments every cycle in REQUEST, WAIT and ACK. If it reaches `TIMEOUT`−1 and the state's exit condition is false that cycle, go to ABORT. An exit condition true in the same cycle wins over timeout.
- **Pass-through:** the tag passes through unchanged. The result is never modified except on abort.

## Timing
- **Reset values:** all outputs 0 (`cmd_ready` = 1 the cycle after reset). FIFO empty, state IDLE, counter 0.
- **Reset mid-operation:** state returns to IDLE on the next edge. The in-flight command and queued commands are discarded, and no result is reported.
- **Command-to-FPU latency:** a command pushed at edge t (FIFO previously empty) is popped at t+1. `fpu_reset` is high during cycle t+1..t+2. `input_rdy` rises at t+2.
- **Handshake rules:**
  - `input_rdy` never drops before `input_ack` is sampled high.
  - `output_ack` never rises before `output_rdy`.
  - `output_ack` stays high until `output_rdy` is sampled low.
- **Minimum command-to-result latency:** 5 cycles when the FPU acks immediately. The path is push, IDLE→CLEAR, REQUEST, ACK, DONE.
- **Back-to-back results:** the earliest next CLEAR is 2 cycles after `res_ready`, via the DONE→IDLE→CLEAR path.
- **Result stall:** `res_valid` is held with data stable indefinitely while `res_ready` = 0. The queue may still accept up to 2 commands.

## Test plan
- **Multiply:** op 0010, a = b = 0x40000000, tag 3, FPU model acks in 2 cycles → `res_data` 0x40800000, `res_tag` 3, `res_timeout` 0. Check one `fpu_reset` pulse before `input_rdy`.
- **Add with same-cycle ack:** op 0000, a 0x3F800000, b 0x3C23D70A; the model asserts `input_ack` and `output_rdy` together → `res_data` 0x3F8147AE. Check WAIT is skipped and `output_ack` holds until `output_rdy` falls.
- **Queue full:** push 3 commands with `res_ready` = 0 → `cmd_ready` falls after 2 pushes. Results return in order with tags 1, 2, 3 once `res_ready` = 1.
- **Timeout:** the model never asserts `output_rdy`, TIMEOUT = 8 → after 8 cycles past CLEAR, `fpu_reset` pulses and the result is 0xFFFFFFFF with `res_timeout` 1. The next command completes normally.
- **Reset mid-operation:** assert `reset` during WAIT → the next cycle has all outputs 0 and `cmd_ready` 1, and no stale `res_valid` appears.
- **Division:** op 0011, a 0x40800000, b 0x40000000, `res_ready` held 0 for 10 cycles → `res_data` 0x40000000 stays stable throughout the stall.
